// File: rtl/pw_change_ctrl.sv
// Password store with a serial verify / enter-new / confirm change sequence.
// Define PW_TIMEOUT_EN to abort an unfinished sequence after TIMEOUT idle cycles.
module pw_change_ctrl #(
  parameter int DIGITS        = 4,
  parameter int DW            = 4,
  parameter int DEFAULT_DIGIT = 6,
  parameter int TIMEOUT       = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 change,
  input  logic [DW-1:0]        digit_in,
  input  logic                 digit_valid,
  input  logic                 cancel,
  output logic [DIGITS*DW-1:0] key_out,
  output logic                 busy,
  output logic [1:0]           state_out,
  output logic                 done,
  output logic                 err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] VERIFY  = 2'd1;
  localparam logic [1:0] NEW     = 2'd2;
  localparam logic [1:0] CONFIRM = 2'd3;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [1:0]                 state;
  logic [CW-1:0]              cnt;
  logic                       mism_flag;
  logic [DIGITS-1:0][DW-1:0]  key;
  logic [DIGITS-1:0][DW-1:0]  shadow;
  logic                       last_digit;
  logic                       digit_mism;
  logic                       timeout_hit;

  assign key_out   = key;
  assign busy      = (state != IDLE);
  assign state_out = state;

  always_comb begin
    last_digit = (cnt == CW'(DIGITS - 1));
    digit_mism = 1'b0;
    if (state == VERIFY)
      digit_mism = (digit_in != key[cnt]);
    else if (state == CONFIRM)
      digit_mism = (digit_in != shadow[cnt]);
  end

`ifdef PW_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;

  // Idle counter restarts on every state entry and every accepted digit.
  always_ff @(posedge clk) begin
    if (reset || !busy || cancel || digit_valid || timeout_hit)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end

  assign timeout_hit = busy && !cancel && !digit_valid &&
                       (idle_cnt == TW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mism_flag <= 1'b0;
      key       <= {DIGITS{DW'(DEFAULT_DIGIT)}};
      shadow    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == IDLE) begin
        if (change) begin
          state     <= VERIFY;
          cnt       <= '0;
          mism_flag <= 1'b0;
        end
      end else if (cancel) begin
        state     <= IDLE;
        cnt       <= '0;
        mism_flag <= 1'b0;
      end else if (digit_valid) begin
        if (state == NEW)
          shadow[cnt] <= digit_in;
        if (!last_digit) begin
          cnt       <= cnt + 1'b1;
          mism_flag <= mism_flag | digit_mism;
        end else begin
          // Final digit: decide the whole phase; the sticky flag starts clean next phase.
          cnt       <= '0;
          mism_flag <= 1'b0;
          case (state)
            VERIFY: begin
              if (mism_flag || digit_mism) begin
                err   <= 1'b1;
                state <= IDLE;
              end else begin
                state <= NEW;
              end
            end
            NEW: state <= CONFIRM;
            default: begin
              if (mism_flag || digit_mism) begin
                err <= 1'b1;
              end else begin
                key  <= shadow;
                done <= 1'b1;
              end
              state <= IDLE;
            end
          endcase
        end
      end else if (timeout_hit) begin
        err       <= 1'b1;
        state     <= IDLE;
        cnt       <= '0;
        mism_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pw_change_ctrl.sv
// Bench for pw_change_ctrl: phase-level reference model, per-cycle compare, directed and random sequences.
module tb_pw_change_ctrl;
  localparam int DIGITS = 4;
  localparam int DW     = 4;
  localparam int DEF    = 6;
  localparam int TO     = 16;
  localparam int KW     = DIGITS * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          change = 1'b0;
  logic [DW-1:0] digit_in = '0;
  logic          digit_valid = 1'b0;
  logic          cancel = 1'b0;
  logic [KW-1:0] key_out;
  logic          busy;
  logic [1:0]    state_out;
  logic          done;
  logic          err;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pw_change_ctrl #(.DIGITS(DIGITS), .DW(DW), .DEFAULT_DIGIT(DEF), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .change(change), .digit_in(digit_in),
    .digit_valid(digit_valid), .cancel(cancel), .key_out(key_out),
    .busy(busy), .state_out(state_out), .done(done), .err(err)
  );

  function automatic logic [KW-1:0] def_key();
    logic [KW-1:0] k;
    for (int i = 0; i < DIGITS; i++) k[i*DW +: DW] = DW'(DEF);
    return k;
  endfunction

  function automatic logic [KW-1:0] put(logic [KW-1:0] b, int n, logic [DW-1:0] d);
    logic [KW-1:0] r;
    r = b;
    r[n*DW +: DW] = d;
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: collects a whole phase of digits, then judges the complete entry.
  int            m_phase = 0;   // 0 idle, 1 verify old key, 2 enter new, 3 confirm
  int            m_n = 0;
  int            m_quiet = 0;
  logic [KW-1:0] m_key = '0;
  logic [KW-1:0] m_shadow = '0;
  logic [KW-1:0] m_buf = '0;
  bit            m_done = 1'b0;
  bit            m_err = 1'b0;

  always @(posedge clk) begin
    m_done <= 1'b0;
    m_err  <= 1'b0;
    if (reset) begin
      m_key <= def_key(); m_phase <= 0; m_n <= 0; m_buf <= '0; m_shadow <= '0; m_quiet <= 0;
    end else if (m_phase == 0) begin
      m_quiet <= 0;
      if (change) begin m_phase <= 1; m_n <= 0; end
    end else if (cancel) begin
      m_phase <= 0; m_n <= 0; m_quiet <= 0;
    end else if (digit_valid) begin
      m_quiet <= 0;
      if (m_n < DIGITS - 1) begin
        m_buf <= put(m_buf, m_n, digit_in);
        m_n   <= m_n + 1;
      end else begin
        m_n <= 0;
        if (m_phase == 1) begin
          if (put(m_buf, m_n, digit_in) == m_key) m_phase <= 2;
          else begin m_err <= 1'b1; m_phase <= 0; end
        end else if (m_phase == 2) begin
          m_shadow <= put(m_buf, m_n, digit_in);
          m_phase  <= 3;
        end else begin
          if (put(m_buf, m_n, digit_in) == m_shadow) begin m_key <= m_shadow; m_done <= 1'b1; end
          else m_err <= 1'b1;
          m_phase <= 0;
        end
      end
    end
`ifdef PW_TIMEOUT_EN
    else if (m_quiet == TO - 1) begin
      m_err <= 1'b1; m_phase <= 0; m_n <= 0; m_quiet <= 0;
    end else begin
      m_quiet <= m_quiet + 1;
    end
`endif
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_key",   64'(key_out),   64'(m_key));
      check("cyc_state", 64'(state_out), 64'(m_phase));
      check("cyc_busy",  64'(busy),      64'(m_phase != 0));
      check("cyc_done",  64'(done),      64'(m_done));
      check("cyc_err",   64'(err),       64'(m_err));
      check("cyc_excl",  64'(done & err), 64'(0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [DW-1:0] d);
    digit_in = d; digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic start();
    change = 1'b1;
    tick();
    change = 1'b0;
  endtask

  task automatic send_key(logic [KW-1:0] k);
    for (int i = 0; i < DIGITS; i++) send(k[i*DW +: DW]);
  endtask

  // Random-gap sequence with an optional cancel riding on digit number cancel_at.
  task automatic send_rand(logic [KW-1:0] k, int cancel_at);
    for (int i = 0; i < DIGITS; i++) begin
      digit_in = k[i*DW +: DW]; digit_valid = 1'b1;
      change = ($urandom_range(0, 7) == 0);
      cancel = (i == cancel_at);
      tick();
      digit_valid = 1'b0; change = 1'b0; cancel = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [KW-1:0] newk, vk, ck;
    int cat;
    reset = 1'b1;
    tick(); tick();
    check("rst_key",   64'(key_out),   64'h6666);
    check("rst_state", 64'(state_out), 64'(0));
    check("rst_busy",  64'(busy),      64'(0));
    check("rst_done",  64'(done),      64'(0));
    check("rst_err",   64'(err),       64'(0));
    reset = 1'b0;
    chk_en = 1'b1;

    // Wrong old key: no early abort, err after the fourth digit.
    start();
    send(6); send(6); send(5);
    check("wrong_noerr_early", 64'(err), 64'(0));
    check("wrong_still_verify", 64'(state_out), 64'(1));
    send(6);
    check("wrong_err", 64'(err), 64'(1));
    check("wrong_key", 64'(key_out), 64'h6666);
    check("wrong_state", 64'(state_out), 64'(0));

    // Confirm mismatch.
    start();
    send_key(16'h6666); send_key(16'h4321); send_key(16'h5321);
    check("cmis_err", 64'(err), 64'(1));
    check("cmis_key", 64'(key_out), 64'h6666);

    // Cancel together with second NEW digit.
    start();
    send_key(16'h6666); send(1);
    digit_in = 4'd2; digit_valid = 1'b1; cancel = 1'b1;
    tick();
    digit_valid = 1'b0; cancel = 1'b0;
    check("cancel_state", 64'(state_out), 64'(0));
    check("cancel_err", 64'(err), 64'(0));
    check("cancel_key", 64'(key_out), 64'h6666);

    // Good change.
    start();
    send_key(16'h6666); send_key(16'h4321);
    check("good_before_done", 64'(done), 64'(0));
    send_key(16'h4321);
    check("good_done", 64'(done), 64'(1));
    check("good_key", 64'(key_out), 64'h4321);
    check("good_state", 64'(state_out), 64'(0));
    tick();
    check("good_done_pulse", 64'(done), 64'(0));

    // Change while busy ignored, then reset inside CONFIRM.
    start();
    send_key(16'h4321); send_key(16'h8888); send(8); send(8);
    check("mid_confirm", 64'(state_out), 64'(3));
    start();
    check("busy_change_ignored", 64'(state_out), 64'(3));
    reset = 1'b1; tick(); reset = 1'b0;
    check("midrst_key", 64'(key_out), 64'h6666);
    check("midrst_state", 64'(state_out), 64'(0));

    // One digit then idle.
    start();
    send(6);
`ifdef PW_TIMEOUT_EN
    repeat (TO - 1) tick();
    check("to_not_yet", 64'(err), 64'(0));
    check("to_still_verify", 64'(state_out), 64'(1));
    tick();
    check("to_err", 64'(err), 64'(1));
    check("to_state", 64'(state_out), 64'(0));
`else
    repeat (100) tick();
    check("noto_verify", 64'(state_out), 64'(1));
    check("noto_err", 64'(err), 64'(0));
    cancel = 1'b1; tick(); cancel = 1'b0;
`endif

    // Random sequences.
    for (int t = 0; t < 150; t++) begin
      if (m_phase != 0) begin cancel = 1'b1; tick(); cancel = 1'b0; end
      if ($urandom_range(0, 29) == 0) begin reset = 1'b1; tick(); reset = 1'b0; end
      newk = KW'($urandom);
      vk   = ($urandom_range(0, 3) == 0) ? put(m_key, $urandom_range(0, DIGITS-1), DW'($urandom)) : m_key;
      ck   = ($urandom_range(0, 3) == 0) ? put(newk, $urandom_range(0, DIGITS-1), DW'($urandom)) : newk;
      cat  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3 * DIGITS - 1)) : -1;
      start();
      send_rand(vk, cat);
      send_rand(newk, cat - DIGITS);
      send_rand(ck, cat - 2 * DIGITS);
`ifdef PW_TIMEOUT_EN
      if ($urandom_range(0, 9) == 0) repeat (TO + 2) tick();
`endif
      repeat ($urandom_range(1, 3)) tick();
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
